vec_acc_frontend: RTL and testbench

Accelerator front end for the vector unit. Accepts scalar-core offload requests (instr, rs1, rs2, instr_id), buffers them in an in-order FIFO and classifies each head entry to a functional unit: lane, vsld, vlsu or msk. Legal entries go to the issue port. Illegal opcodes are retired locally with an error response. Backend completions and local errors are merged into one registered response channel back to the scalar core.

---
 rtl/vec_acc_frontend.sv | 199 +++++++++++++++++++
 tb/tb_vec_acc_frontend.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_acc_frontend.sv
// Vector accelerator front end: in-order request FIFO, head classifier, issue port and a
// one-entry response register. Optional same-cycle bypass when VEC_FE_BYPASS_EN is defined.
module vec_acc_frontend #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned INSTR_BITS    = 32,
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [INSTR_BITS-1:0]    req_instr_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  input  logic [TRANS_ID_BITS-1:0] req_id_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [INSTR_BITS-1:0]    issue_instr_o,
  output logic [XLEN-1:0]          issue_rs1_o,
  output logic [XLEN-1:0]          issue_rs2_o,
  output logic [TRANS_ID_BITS-1:0] issue_id_o,
  output logic [1:0]               issue_unit_o,
  input  logic                     done_valid_i,
  output logic                     done_ready_o,
  input  logic                     done_err_i,
  input  logic [XLEN-1:0]          done_res_i,
  input  logic [TRANS_ID_BITS-1:0] done_id_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic                     resp_err_o,
  output logic [XLEN-1:0]          resp_res_o,
  output logic [TRANS_ID_BITS-1:0] resp_id_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] UnitLane = 2'd0;
  localparam logic [1:0] UnitVsld = 2'd1;
  localparam logic [1:0] UnitVlsu = 2'd2;
  localparam logic [1:0] UnitMsk  = 2'd3;

  // Returns {illegal, unit}.
  function automatic logic [2:0] classify(input logic [6:0] opcode, input logic [2:0] funct3,
                                          input logic [5:0] funct6);
    logic [2:0] cls;
    cls = {1'b1, UnitLane};
    if (opcode == 7'b0000111 || opcode == 7'b0100111) begin
      cls = {1'b0, UnitVlsu};
    end else if (opcode == 7'b1010111) begin
      if (funct3 == 3'b111) begin
        cls = {1'b1, UnitLane};
      end else if (funct6[5:2] == 4'b0011) begin
        cls = {1'b0, UnitVsld};
      end else if (funct3 == 3'b010 &&
                   (funct6[5:3] == 3'b000 || funct6 == 6'b010111 ||
                    (funct6[5:4] == 2'b11 && funct6[3:1] == 3'b000))) begin
        cls = {1'b0, UnitVsld};
      end else if (funct3 == 3'b010 &&
                   ((funct6[5:3] == 3'b010 && !funct6[2]) || funct6[5:3] == 3'b011)) begin
        cls = {1'b0, UnitMsk};
      end else begin
        cls = {1'b0, UnitLane};
      end
    end
    return cls;
  endfunction

  logic [INSTR_BITS-1:0]    instr_mem [DEPTH];
  logic [XLEN-1:0]          rs1_mem   [DEPTH];
  logic [XLEN-1:0]          rs2_mem   [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem    [DEPTH];

  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, pop_legal, pop_err;
  logic            head_valid, head_legal;
  logic [2:0]      head_cls;
  logic            bypass;

  logic [INSTR_BITS-1:0]    head_instr;
  logic [TRANS_ID_BITS-1:0] head_id;

  logic                     resp_valid_q, resp_err_q;
  logic [XLEN-1:0]          resp_res_q;
  logic [TRANS_ID_BITS-1:0] resp_id_q;

  assign head_instr  = instr_mem[rptr_q];
  assign head_id     = id_mem[rptr_q];
  assign head_valid  = (count_q != '0);
  assign head_cls    = classify(head_instr[6:0], head_instr[14:12], head_instr[31:26]);
  assign head_legal  = head_valid & !head_cls[2];
  assign req_ready_o = (count_q != CntW'(DEPTH));

`ifdef VEC_FE_BYPASS_EN
  logic [2:0] req_cls;
  assign req_cls = classify(req_instr_i[6:0], req_instr_i[14:12], req_instr_i[31:26]);
  assign bypass  = !head_valid & req_valid_i & !req_cls[2];
  // A bypassed request that the backend takes immediately never occupies a FIFO slot.
  assign push    = req_valid_i & req_ready_o & !(bypass & issue_ready_i);
`else
  assign bypass  = 1'b0;
  assign push    = req_valid_i & req_ready_o;
`endif

  assign pop_legal = head_legal & issue_ready_i;
  assign pop_err   = head_valid & head_cls[2] & done_ready_o & !done_valid_i;
  assign pop       = pop_legal | pop_err;

  always_comb begin
    issue_valid_o = 1'b0;
    issue_instr_o = '0;
    issue_rs1_o   = '0;
    issue_rs2_o   = '0;
    issue_id_o    = '0;
    issue_unit_o  = UnitLane;
    if (head_legal) begin
      issue_valid_o = 1'b1;
      issue_instr_o = head_instr;
      issue_rs1_o   = rs1_mem[rptr_q];
      issue_rs2_o   = rs2_mem[rptr_q];
      issue_id_o    = head_id;
      issue_unit_o  = head_cls[1:0];
    end
`ifdef VEC_FE_BYPASS_EN
    else if (bypass) begin
      issue_valid_o = 1'b1;
      issue_instr_o = req_instr_i;
      issue_rs1_o   = req_rs1_i;
      issue_rs2_o   = req_rs2_i;
      issue_id_o    = req_id_i;
      issue_unit_o  = req_cls[1:0];
    end
`endif
  end

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem[wptr_q] <= req_instr_i;
      rs1_mem[wptr_q]   <= req_rs1_i;
      rs2_mem[wptr_q]   <= req_rs2_i;
      id_mem[wptr_q]    <= req_id_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + PtrW'(1);
      if (pop)  rptr_q <= rptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Backend completions win over locally retired illegal entries.
  assign done_ready_o = !resp_valid_q | resp_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_res_q   <= '0;
      resp_id_q    <= '0;
    end else if (done_ready_o) begin
      if (done_valid_i) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= done_err_i;
        resp_res_q   <= done_res_i;
        resp_id_q    <= done_id_i;
      end else if (pop_err) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= 1'b1;
        resp_res_q   <= '0;
        resp_id_q    <= head_id;
      end else begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_res_o   = resp_res_q;
  assign resp_id_o    = resp_id_q;

endmodule

// File: tb/tb_vec_acc_frontend.sv
// Self-checking bench for vec_acc_frontend: directed scenarios plus random traffic, all checked
// every cycle against a queue-based behavioural model.
module tb_vec_acc_frontend;

  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_instr_i, req_rs1_i, req_rs2_i;
  logic [3:0]  req_id_i;
  logic        issue_valid_o, issue_ready_i;
  logic [31:0] issue_instr_o, issue_rs1_o, issue_rs2_o;
  logic [3:0]  issue_id_o;
  logic [1:0]  issue_unit_o;
  logic        done_valid_i, done_ready_o, done_err_i;
  logic [31:0] done_res_i;
  logic [3:0]  done_id_i;
  logic        resp_valid_o, resp_ready_i, resp_err_o;
  logic [31:0] resp_res_o;
  logic [3:0]  resp_id_o;

  vec_acc_frontend #(.DEPTH(DEPTH), .INSTR_BITS(32), .XLEN(32), .TRANS_ID_BITS(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_id_i(req_id_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_instr_o(issue_instr_o), .issue_rs1_o(issue_rs1_o), .issue_rs2_o(issue_rs2_o),
    .issue_id_o(issue_id_o), .issue_unit_o(issue_unit_o),
    .done_valid_i(done_valid_i), .done_ready_o(done_ready_o), .done_err_i(done_err_i),
    .done_res_i(done_res_i), .done_id_i(done_id_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_err_o(resp_err_o),
    .resp_res_o(resp_res_o), .resp_id_o(resp_id_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  id;
  } req_t;

  req_t        m_q[$];
  logic        m_rv, m_rerr;
  logic [31:0] m_rres;
  logic [3:0]  m_rid;
  logic        m_accepted;
  int          n_err = 0;
  int          n_checks = 0;

  // Reference decode: -1 illegal, otherwise the functional unit number.
  function automatic int ref_unit(input logic [31:0] instr);
    int op, f3, f6;
    op = int'(instr[6:0]);
    f3 = int'(instr[14:12]);
    f6 = int'(instr[31:26]);
    if (op == 'h07 || op == 'h27) return 2;
    if (op != 'h57) return -1;
    if (f3 == 7) return -1;
    if (f6 >= 12 && f6 <= 15) return 1;
    if (f3 == 2) begin
      if (f6 < 8 || f6 == 23 || f6 == 48 || f6 == 49) return 1;
      if ((f6 >= 16 && f6 <= 19) || (f6 >= 24 && f6 <= 31)) return 3;
    end
    return 0;
  endfunction

  function automatic logic [31:0] mk_v(input logic [5:0] f6, input logic [2:0] f3);
    return {f6, 1'b1, 5'd2, 5'd3, f3, 5'd1, 7'h57};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_rv = 1'b0; m_rerr = 1'b0; m_rres = '0; m_rid = '0;
  endtask

  task automatic check_outputs();
    logic exp_iv;
    req_t h;
    int   u;
    exp_iv = 1'b0;
    u = 0;
    h = '{instr: '0, rs1: '0, rs2: '0, id: '0};
    if (m_q.size() > 0 && ref_unit(m_q[0].instr) >= 0) begin
      exp_iv = 1'b1; h = m_q[0]; u = ref_unit(h.instr);
    end
`ifdef VEC_FE_BYPASS_EN
    if (m_q.size() == 0 && req_valid_i && ref_unit(req_instr_i) >= 0) begin
      exp_iv = 1'b1; u = ref_unit(req_instr_i);
      h = '{instr: req_instr_i, rs1: req_rs1_i, rs2: req_rs2_i, id: req_id_i};
    end
`endif
    chk("req_ready", 32'(req_ready_o), 32'(m_q.size() < DEPTH));
    chk("issue_valid", 32'(issue_valid_o), 32'(exp_iv));
    if (exp_iv) begin
      chk("issue_instr", issue_instr_o, h.instr);
      chk("issue_rs1", issue_rs1_o, h.rs1);
      chk("issue_rs2", issue_rs2_o, h.rs2);
      chk("issue_id", 32'(issue_id_o), 32'(h.id));
      chk("issue_unit", 32'(issue_unit_o), 32'(u));
    end
    chk("done_ready", 32'(done_ready_o), 32'(!m_rv || resp_ready_i));
    chk("resp_valid", 32'(resp_valid_o), 32'(m_rv));
    if (m_rv) begin
      chk("resp_err", 32'(resp_err_o), 32'(m_rerr));
      chk("resp_res", resp_res_o, m_rres);
      chk("resp_id", 32'(resp_id_o), 32'(m_rid));
    end
  endtask

  task automatic model_update();
    logic take, load, head_ok, pop;
    m_accepted = 1'b0;
    if (rst_i) begin
      model_reset();
      return;
    end
    take = 1'b0;
`ifdef VEC_FE_BYPASS_EN
    take = (m_q.size() == 0) && req_valid_i && ref_unit(req_instr_i) >= 0 && issue_ready_i;
`endif
    load    = !m_rv || resp_ready_i;
    head_ok = m_q.size() > 0 && ref_unit(m_q[0].instr) >= 0;
    pop     = 1'b0;
    if (load) begin
      if (done_valid_i) begin
        m_rv = 1'b1; m_rerr = done_err_i; m_rres = done_res_i; m_rid = done_id_i;
      end else if (m_q.size() > 0 && !head_ok) begin
        m_rv = 1'b1; m_rerr = 1'b1; m_rres = '0; m_rid = m_q[0].id; pop = 1'b1;
      end else begin
        m_rv = 1'b0;
      end
    end
    if (head_ok && issue_ready_i) pop = 1'b1;
    m_accepted = req_valid_i && (take || m_q.size() < DEPTH);
    if (pop) void'(m_q.pop_front());
    if (req_valid_i && !take && m_q.size() + (pop ? 1 : 0) < DEPTH)
      m_q.push_back('{instr: req_instr_i, rs1: req_rs1_i, rs2: req_rs2_i, id: req_id_i});
  endtask

  task automatic cycle();
    @(negedge clk_i);
    check_outputs();
    @(posedge clk_i);
    model_update();
    #1;
  endtask

  task automatic set_req(input logic v, input logic [31:0] instr, input logic [3:0] id);
    req_valid_i = v; req_instr_i = instr; req_id_i = id;
    req_rs1_i = $urandom; req_rs2_i = $urandom;
  endtask

  // Hold a request until accepted, bounded.
  task automatic send(input logic [31:0] instr, input logic [3:0] id, input int bound);
    int n;
    set_req(1'b1, instr, id);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!m_accepted && n < bound);
    if (!m_accepted) chk("send_timeout", 32'(m_accepted), 32'd1);
    req_valid_i = 1'b0;
  endtask

  task automatic check_reset_values();
    chk("rst_req_ready", 32'(req_ready_o), 32'd1);
    chk("rst_issue_valid", 32'(issue_valid_o), 32'd0);
    chk("rst_issue_unit", 32'(issue_unit_o), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid_o), 32'd0);
    chk("rst_resp_err", 32'(resp_err_o), 32'd0);
    chk("rst_resp_res", resp_res_o, 32'd0);
    chk("rst_resp_id", 32'(resp_id_o), 32'd0);
    chk("rst_done_ready", 32'(done_ready_o), 32'd1);
  endtask

  logic [31:0] instr_r;
  logic [31:0] sweep[5];

  initial begin
    rst_i = 1'b1;
    set_req(1'b0, '0, '0);
    issue_ready_i = 1'b1; resp_ready_i = 1'b1;
    done_valid_i = 1'b0; done_err_i = 1'b0; done_res_i = '0; done_id_i = '0;
    model_reset();
    cycle();
    cycle();
    check_reset_values();
    rst_i = 1'b0;
    cycle();

    // vadd.vv to lane, then an illegal opcode retired locally
    send(32'h02208057, 4'd3, 4);
    cycle();
    send(32'h0000007F, 4'd5, 4);
    repeat (3) cycle();

    // Fill the FIFO behind a stalled backend, then drain in order
    issue_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) send(32'h02208057, 4'(i), 4);
    set_req(1'b1, 32'h02208057, 4'd4);
    repeat (3) cycle();
    issue_ready_i = 1'b1;
    send(32'h02208057, 4'd4, 8);
    repeat (6) cycle();

    // Completion collides with a waiting illegal head; response held under backpressure
    send(32'h0000007F, 4'd2, 4);
    done_valid_i = 1'b1; done_id_i = 4'd7; done_res_i = 32'hDEADBEEF; done_err_i = 1'b0;
    cycle();
    done_valid_i = 1'b0;
    resp_ready_i = 1'b0;
    repeat (3) cycle();
    resp_ready_i = 1'b1;
    repeat (3) cycle();

    // Classification sweep: vle32, vslideup.vi, vredsum, vmand, vsetvli
    sweep[0] = 32'h02056007;
    sweep[1] = mk_v(6'b001110, 3'b011);
    sweep[2] = mk_v(6'b000000, 3'b010);
    sweep[3] = mk_v(6'b011001, 3'b010);
    sweep[4] = {1'b0, 11'h0, 5'd1, 3'b111, 5'd1, 7'h57};
    for (int i = 0; i < 5; i++) send(sweep[i], 4'(8 + i), 4);
    repeat (4) cycle();

    // Asynchronous reset with entries queued and a response pending
    resp_ready_i = 1'b0;
    send(32'h0000007F, 4'd9, 4);
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) send(32'h02208057, 4'(10 + i), 4);
    cycle();
    #2 rst_i = 1'b1;
    model_reset();
    #1 check_reset_values();
    cycle();
    rst_i = 1'b0;
    issue_ready_i = 1'b1; resp_ready_i = 1'b1;
    send(32'h02208057, 4'd6, 4);
    repeat (2) cycle();

    // Random traffic
    for (int c = 0; c < 500; c++) begin
      case ($urandom_range(0, 5))
        0:       instr_r = {$urandom, 7'h07} >> 0;
        1:       instr_r = 32'h00000027 | ($urandom & 32'hFFFFFF80);
        2:       instr_r = $urandom;
        default: instr_r = mk_v(6'($urandom), 3'($urandom)) ^ ($urandom & 32'h03FF8F80);
      endcase
      if ($urandom_range(0, 5) == 0) instr_r[6:0] = 7'h07;
      set_req(1'($urandom_range(0, 2) != 0), instr_r, 4'($urandom));
      issue_ready_i = 1'($urandom_range(0, 3) != 0);
      resp_ready_i  = 1'($urandom_range(0, 3) != 0);
      done_valid_i  = 1'($urandom_range(0, 3) == 0);
      done_err_i    = 1'($urandom);
      done_res_i    = $urandom;
      done_id_i     = 4'($urandom);
      cycle();
    end
    req_valid_i = 1'b0; done_valid_i = 1'b0;
    issue_ready_i = 1'b1; resp_ready_i = 1'b1;
    repeat (8) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
